// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises stream words LSB-first into a config chain.
// Define CCFF_READBACK_SIG_EN to add an LFSR signature of ccff_tail.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 88,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
`ifdef CCFF_READBACK_SIG_EN
  input  logic              sig_clear,
  output logic [15:0]       readback_sig,
`endif
  output logic              busy,
  output logic              done
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int SC_W      = $clog2(WORD_W + 1);
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  NW_C     = WC_W'(NUM_WORDS);
  localparam logic [WC_W-1:0]  LAST_IDX = WC_W'(NUM_WORDS - 1);
  localparam logic [SC_W-1:0]  FULL_C   = SC_W'(WORD_W);
  localparam logic [SC_W-1:0]  LAST_C   = SC_W'(LAST_BITS);
  localparam logic [SC_W-1:0]  ONE_C    = SC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t st, st_nxt;

  logic [WORD_W-1:0] hr;
  logic [WORD_W-1:0] sr;
  logic              hr_full;
  logic              hr_last;
  logic [SC_W-1:0]   sr_cnt;
  logic [CNT_W-1:0]  bits_sent;
  logic [WC_W-1:0]   words_acc;

  logic start_acc;
  logic emit;
  logic reload;
  logic xfer;
  logic finish;

  assign start_acc = (st == S_IDLE) && start && !abort;
  assign emit      = (st == S_ACTIVE) && (sr_cnt != '0);
  assign reload    = (st == S_ACTIVE) && hr_full && (sr_cnt <= ONE_C);
  assign xfer      = s_valid && s_ready && !abort;
  assign finish    = (st == S_ACTIVE) && (bits_sent == LEN_C);

  // State register
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) st <= S_IDLE;
    else            st <= st_nxt;
  end

  // Next-state logic; abort wins over everything
  always_comb begin
    st_nxt = st;
    if (abort) begin
      st_nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE:   if (start) st_nxt = S_ACTIVE;
        S_ACTIVE: if (bits_sent == LEN_C) st_nxt = S_DONE;
        S_DONE:   st_nxt = S_IDLE;
        default:  st_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy    = (st == S_ACTIVE);
    s_ready = (st == S_ACTIVE) && !hr_full && (words_acc < NW_C);
  end

  // Holding register and accepted-word counter
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      hr        <= '0;
      hr_full   <= 1'b0;
      hr_last   <= 1'b0;
      words_acc <= '0;
    end else if (abort || start_acc) begin
      hr        <= '0;
      hr_full   <= 1'b0;
      hr_last   <= 1'b0;
      words_acc <= '0;
    end else if (xfer) begin
      hr        <= s_data;
      hr_full   <= 1'b1;
      hr_last   <= (words_acc == LAST_IDX);
      words_acc <= words_acc + 1'b1;
    end else if (reload) begin
      hr_full   <= 1'b0;
    end
  end

  // Shift register, bit counter and registered chain outputs
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sr            <= '0;
      sr_cnt        <= '0;
      bits_sent     <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else if (abort || start_acc) begin
      sr            <= '0;
      sr_cnt        <= '0;
      bits_sent     <= '0;
      ccff_shift_en <= 1'b0;
    end else begin
      ccff_shift_en <= emit;
      if (emit) begin
        ccff_head <= sr[0];
        bits_sent <= bits_sent + 1'b1;
      end
      if (reload) begin
        sr     <= hr;
        sr_cnt <= hr_last ? LAST_C : FULL_C;
      end else if (emit) begin
        sr     <= sr >> 1;
        sr_cnt <= sr_cnt - 1'b1;
      end
    end
  end

  // Sticky completion flag, cleared only by an accepted start
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset)          done <= 1'b0;
    else if (start_acc)      done <= 1'b0;
    else if (finish && !abort) done <= 1'b1;
  end

`ifdef CCFF_READBACK_SIG_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10] ^ ccff_tail;
  assign readback_sig = lfsr;

  // Fold the outgoing chain content into the signature on each shift
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset)                  lfsr <= 16'hFFFF;
    else if (sig_clear || start_acc) lfsr <= 16'hFFFF;
    else if (ccff_shift_en)          lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: table, directed and random checks
// of the config-chain loader with CHAIN_LEN=10, WORD_W=4.
module tb_ccff_bitstream_loader;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int NW = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic [WW-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic ccff_head;
  logic ccff_shift_en;
  logic ccff_tail;
  logic busy;
  logic done;
`ifdef CCFF_READBACK_SIG_EN
  logic sig_clear;
  logic [15:0] readback_sig;
`endif

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start),
    .abort        (abort),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
`ifdef CCFF_READBACK_SIG_EN
    .sig_clear    (sig_clear),
    .readback_sig (readback_sig),
`endif
    .busy         (busy),
    .done         (done)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic st, ab, sv;
    logic [WW-1:0] d;
    logic rdy, sh, hd, bz, dn;
  } vec_t;

  vec_t tbl[16];

  logic [WW-1:0] src_q[$];
  int valid_pct = 100;
  int stall_after = -1;
  int stall_len = 0;
  bit heads[$];
  int pcyc[$];
  int done_cyc;
  int acc_cnt;

  function automatic bit model_bit(int i);
    logic [WW-1:0] w;
    w = src_q[i / WW];
    return w[i % WW];
  endfunction

  // One load: start, feed src_q, collect chain bits until done/abort.
  task automatic load(input int abort_at, input int restart_cyc);
    int widx = 0;
    int cyc = 0;
    int stall_left = 0;
    int post = 0;
    bit hs;
    bit ab_done = 0;
    heads.delete();
    pcyc.delete();
    done_cyc = -1;
    start = 1; abort = 0; s_valid = 0; s_data = '0;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_done_clr", {31'd0, done}, 0);
    while (cyc < 300) begin
      if (ccff_shift_en) begin
        heads.push_back(ccff_head);
        pcyc.push_back(cyc);
      end
      if (ab_done) begin
        post++;
        if (post == 1) begin
          chk("abort_shift_en", {31'd0, ccff_shift_en}, 0);
          chk("abort_busy", {31'd0, busy}, 0);
          chk("abort_done", {31'd0, done}, 0);
          chk("abort_s_ready", {31'd0, s_ready}, 0);
        end
        if (post == 3) break;
      end else if (done) begin
        done_cyc = cyc;
        break;
      end
      abort = 0;
      if (!ab_done && abort_at > 0 && ccff_shift_en &&
          heads.size() == abort_at) begin
        abort = 1;
        ab_done = 1;
      end
      start = (cyc == restart_cyc);
      s_valid = (widx < src_q.size()) && (stall_left == 0) &&
                ($urandom_range(99) < valid_pct);
      s_data = (widx < src_q.size()) ? src_q[widx] : WW'($urandom);
      @(negedge clk);
      hs = s_valid && s_ready && !abort;
      @(posedge clk); #1;
      if (stall_left > 0) stall_left--;
      if (hs) begin
        widx++;
        if (widx == stall_after) stall_left = stall_len;
      end
      cyc++;
    end
    abort = 0; start = 0; s_valid = 0;
    acc_cnt = widx;
    if (cyc >= 300) begin
      n_vec++;
      n_bad++;
      $display("FAIL load_timeout: got no done after %0d cycles", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_full(input string nm);
    chk({nm, "_count"}, heads.size(), CL);
    for (int i = 0; i < heads.size() && i < CL; i++)
      chk({nm, "_bit"}, {31'd0, heads[i]}, {31'd0, model_bit(i)});
    if (pcyc.size() > 0)
      chk({nm, "_done_lat"}, done_cyc, pcyc[pcyc.size() - 1] + 1);
  endtask

`ifdef CCFF_READBACK_SIG_EN
  function automatic logic [15:0] sig_model(int n, bit t);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++)
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ t};
    return s;
  endfunction
`endif

  bit exp_seq[CL] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};

  initial begin
    // st ab sv d  rdy sh hd bz dn
    tbl[0]  = '{1, 0, 1, 4'hA, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 4'hA, 1, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 4'hA, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 4'h5, 1, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 4'h5, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 4'h5, 0, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 4'h5, 0, 1, 0, 1, 0};
    tbl[7]  = '{0, 0, 1, 4'hF, 1, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 1, 4'hF, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 1, 4'hF, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 4'hF, 0, 1, 1, 1, 0};
    tbl[11] = '{0, 0, 1, 4'hF, 0, 1, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 4'hF, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 0, 1, 4'hF, 0, 1, 1, 1, 0};
    tbl[14] = '{0, 0, 1, 4'hF, 0, 0, 1, 0, 1};
    tbl[15] = '{0, 0, 1, 4'hF, 0, 0, 1, 0, 1};

    rst = 1; start = 0; abort = 0; s_valid = 0;
    s_data = '0; ccff_tail = 0;
`ifdef CCFF_READBACK_SIG_EN
    sig_clear = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_head", {31'd0, ccff_head}, 0);
    chk("rst_shift_en", {31'd0, ccff_shift_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
`ifdef CCFF_READBACK_SIG_EN
    chk("rst_sig", {16'd0, readback_sig}, 32'hFFFF);
`endif
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1;
      s_data = WW'($urandom);
      @(negedge clk);
      chk("idle_s_ready", {31'd0, s_ready}, 0);
      chk("idle_outs", {28'd0, ccff_head, ccff_shift_en, busy, done}, 0);
      @(posedge clk); #1;
    end

    for (int r = 0; r < 16; r++) begin
      start = tbl[r].st;
      abort = tbl[r].ab;
      s_valid = tbl[r].sv;
      s_data = tbl[r].d;
      @(negedge clk);
      chk($sformatf("tbl%0d_s_ready", r), {31'd0, s_ready}, {31'd0, tbl[r].rdy});
      chk($sformatf("tbl%0d_shift_en", r), {31'd0, ccff_shift_en}, {31'd0, tbl[r].sh});
      chk($sformatf("tbl%0d_head", r), {31'd0, ccff_head}, {31'd0, tbl[r].hd});
      chk($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].bz});
      chk($sformatf("tbl%0d_done", r), {31'd0, done}, {31'd0, tbl[r].dn});
      @(posedge clk); #1;
    end
    start = 0; s_valid = 0;

    src_q = '{4'hA, 4'h5, 4'hF};
    stall_after = 1; stall_len = 5;
    load(0, 0);
    check_full("starve");
    for (int i = 0; i < heads.size() && i < CL; i++)
      chk("starve_spec_bit", {31'd0, heads[i]}, {31'd0, exp_seq[i]});
    if (pcyc.size() == CL)
      chk("starve_gap", {31'd0, (pcyc[CL - 1] - pcyc[0]) > CL - 1}, 1);
    stall_after = -1; stall_len = 0;

    load(6, 0);
    chk("abort_pulses", heads.size(), 6);
    load(0, 0);
    check_full("reload");

    load(0, 5);
    check_full("restart");
    if (pcyc.size() == CL) begin
      chk("restart_first", pcyc[0], 4);
      chk("restart_contig", pcyc[CL - 1] - pcyc[0], CL - 1);
    end

    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("sa_busy", {31'd0, busy}, 0);
      chk("sa_shift_en", {31'd0, ccff_shift_en}, 0);
      chk("sa_s_ready", {31'd0, s_ready}, 0);
      chk("sa_done", {31'd0, done}, 1);
      @(posedge clk); #1;
    end

    for (int it = 0; it < 40; it++) begin
      int n;
      int ab;
      src_q.delete();
      n = NW + int'($urandom_range(1));
      for (int k = 0; k < n; k++) src_q.push_back(WW'($urandom));
      valid_pct = $urandom_range(100, 30);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(CL, 1)) : 0;
      load(ab, 0);
      if (ab > 0) begin
        chk("rnd_abort_count", heads.size(), ab);
        for (int i = 0; i < heads.size() && i < CL; i++)
          chk("rnd_abort_bit", {31'd0, heads[i]}, {31'd0, model_bit(i)});
      end else begin
        check_full("rnd");
        chk("rnd_words", acc_cnt, NW);
      end
    end
    valid_pct = 100;

    start = 1; s_valid = 1; s_data = 4'hA;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("midrst_outs",
        {27'd0, s_ready, ccff_head, ccff_shift_en, busy, done}, 0);
    @(posedge clk); #1;
    rst = 0; s_valid = 0;
    @(posedge clk); #1;

`ifdef CCFF_READBACK_SIG_EN
    ccff_tail = 1;
    src_q = '{4'hA, 4'h5, 4'hF};
    load(0, 0);
    check_full("sig");
    chk("sig_value", {16'd0, readback_sig}, {16'd0, sig_model(CL, 1'b1)});
    ccff_tail = 0;
    sig_clear = 1;
    @(posedge clk); #1;
    sig_clear = 0;
    chk("sig_clear", {16'd0, readback_sig}, 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
